// File: rtl/posit_defines.sv
// Shared posit<4,0> constants for the quire-to-posit datapath.
package posit_defines;

   localparam int unsigned POSIT4_WIDTH = 4;
   localparam int unsigned POSIT4_ES    = 0;
   // Minimum quire width before carry-guard bits are added
   localparam int unsigned NQMIN        = 9;
   // Binary point position inside the quire (LSB weight 2^-QUIRE_BPP)
   localparam int unsigned QUIRE_BPP    = 4;

   localparam logic [POSIT4_WIDTH-1:0] POSIT4_NAR  = 4'b1000;
   localparam logic [POSIT4_WIDTH-1:0] POSIT4_ZERO = 4'b0000;

   // Magnitude field limits (bits below the sign)
   localparam logic [POSIT4_WIDTH-2:0] POSIT4_MAXPOS_FIELD = 3'b111;
   localparam logic [POSIT4_WIDTH-2:0] POSIT4_MINPOS_FIELD = 3'b001;

endpackage

// File: rtl/leading_one_detector.sv
// Combinational priority encoder: position of the most significant set bit.
module leading_one_detector #(
   parameter int unsigned WIDTH = 19,
   localparam int unsigned PW = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] in_i,
   output logic [PW-1:0]    pos_o,
   output logic             valid_o
);

   // Scan upward so the highest set bit wins
   always_comb begin
      pos_o   = '0;
      valid_o = 1'b0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         if (in_i[i]) begin
            pos_o   = PW'(i);
            valid_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/quire_to_posit_4_0.sv
// Quire to posit<4,0> converter: 3-stage pipeline (magnitude, normalize, round/encode)
// with rts/rtr handshake. Optional macro QUIRE2POSIT_EOW_ONLY_EN emits only end-of-window beats.
module quire_to_posit_4_0
   import posit_defines::*;
#(
   parameter int unsigned LOG_NB_ACCUM = 10,
   localparam int unsigned QW = NQMIN + LOG_NB_ACCUM,
   localparam int unsigned PW = $clog2(QW)
) (
   input  logic          clk,
   input  logic          rst,
   output logic          rtr_o,
   input  logic          rts_i,
   input  logic          sow_i,
   input  logic          eow_i,
   input  logic [QW-1:0] data_i,
   input  logic          sign_i,
   input  logic          zero_i,
   input  logic          NaR_i,
   input  logic          rtr_i,
   output logic          rts_o,
   output logic          sow_o,
   output logic          eow_o,
   output logic [3:0]    posit_o,
   output logic          sign_o,
   output logic          zero_o,
   output logic          NaR_o
);

   // Scratch width for the regime + fraction bit string
   localparam int unsigned VW = QW + 2;

   // Sign is recomputed from the quire MSB
   logic unused_sign;
   assign unused_sign = sign_i;

   logic process_en, accept, load1;
   logic rtr_q, rtr_d;

   logic          v1_q, v1_d, neg1_q, neg1_d, nar1_q, nar1_d, zero1_q, zero1_d;
   logic          sow1_q, sow1_d, eow1_q, eow1_d;
   logic [QW-1:0] mag1_q, mag1_d;

   logic              v2_q, v2_d, neg2_q, neg2_d, nar2_q, nar2_d, zero2_q, zero2_d;
   logic              sow2_q, sow2_d, eow2_q, eow2_d, sticky2_q, sticky2_d;
   logic [1:0]        frac2_q, frac2_d;
   logic signed [PW:0] scale2_q, scale2_d;

   logic       rts_q, rts_d, sow_o_q, sow_o_d, eow_o_q, eow_o_d;
   logic [3:0] posit_q, posit_d;

   logic [QW-1:0] mag_in, norm;
   logic [PW-1:0] lzd_pos, shamt;
   logic          lzd_valid;

   logic [PW:0]   k;
   logic [VW-1:0] vec;
   logic [2:0]    field, res;
   logic [3:0]    sum, enc;
   logic          guard, stk, round_up;

   assign process_en = rtr_i | ~rts_q;
   assign accept     = rts_i & rtr_q & process_en;
`ifdef QUIRE2POSIT_EOW_ONLY_EN
   assign load1 = accept & eow_i;
`else
   assign load1 = accept;
`endif

   assign mag_in = data_i[QW-1] ? (~data_i + QW'(1)) : data_i;

   leading_one_detector #(
      .WIDTH(QW)
   ) u_lzd (
      .in_i   (mag1_q),
      .pos_o  (lzd_pos),
      .valid_o(lzd_valid)
   );

   assign shamt = PW'(QW - 1) - lzd_pos;
   assign norm  = mag1_q << shamt;

   // Round/encode: build regime+fraction string, round to nearest even, clamp, negate
   always_comb begin
      if (!scale2_q[PW]) begin
         k   = $unsigned(scale2_q) + (PW+1)'(1);
         vec = ~({VW{1'b1}} >> k);
      end else begin
         k   = $unsigned(-scale2_q);
         vec = {1'b1, {(VW-1){1'b0}}} >> k;
      end
      vec      = vec | ({frac2_q, {(VW-2){1'b0}}} >> (k + (PW+1)'(1)));
      field    = vec[VW-1 -: 3];
      guard    = vec[VW-4];
      stk      = (|vec[VW-5:0]) | sticky2_q;
      round_up = guard & (stk | field[0]);
      sum      = {1'b0, field} + {3'b000, round_up};
      if (sum[3]) begin
         res = POSIT4_MAXPOS_FIELD;
      end else if (sum[2:0] == 3'b000) begin
         res = POSIT4_MINPOS_FIELD;
      end else begin
         res = sum[2:0];
      end
      enc = neg2_q ? (~{1'b0, res} + 4'd1) : {1'b0, res};
   end

   // Next-state for all stages; everything holds while process_en is low
   always_comb begin
      rtr_d     = process_en;
      v1_d      = v1_q;
      neg1_d    = neg1_q;
      nar1_d    = nar1_q;
      zero1_d   = zero1_q;
      sow1_d    = sow1_q;
      eow1_d    = eow1_q;
      mag1_d    = mag1_q;
      v2_d      = v2_q;
      neg2_d    = neg2_q;
      nar2_d    = nar2_q;
      zero2_d   = zero2_q;
      sow2_d    = sow2_q;
      eow2_d    = eow2_q;
      sticky2_d = sticky2_q;
      frac2_d   = frac2_q;
      scale2_d  = scale2_q;
      rts_d     = rts_q;
      sow_o_d   = sow_o_q;
      eow_o_d   = eow_o_q;
      posit_d   = posit_q;
      if (process_en) begin
         v1_d = load1;
         if (load1) begin
            neg1_d  = data_i[QW-1];
            mag1_d  = mag_in;
            nar1_d  = NaR_i;
            zero1_d = zero_i | (mag_in == '0);
            sow1_d  = sow_i;
            eow1_d  = eow_i;
         end
         v2_d = v1_q;
         if (v1_q) begin
            neg2_d    = neg1_q;
            nar2_d    = nar1_q;
            zero2_d   = zero1_q | ~lzd_valid;
            sow2_d    = sow1_q;
            eow2_d    = eow1_q;
            scale2_d  = $signed({1'b0, lzd_pos}) - $signed((PW+1)'(QUIRE_BPP));
            frac2_d   = norm[QW-2 -: 2];
            sticky2_d = |norm[QW-4:0];
         end
         rts_d = v2_q;
         if (v2_q) begin
            sow_o_d = sow2_q;
            eow_o_d = eow2_q;
            if (nar2_q) begin
               posit_d = POSIT4_NAR;
            end else if (zero2_q) begin
               posit_d = POSIT4_ZERO;
            end else begin
               posit_d = enc;
            end
         end
      end
   end

   // Pipeline registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         rtr_q     <= 1'b0;
         v1_q      <= 1'b0;
         neg1_q    <= 1'b0;
         nar1_q    <= 1'b0;
         zero1_q   <= 1'b0;
         sow1_q    <= 1'b0;
         eow1_q    <= 1'b0;
         mag1_q    <= '0;
         v2_q      <= 1'b0;
         neg2_q    <= 1'b0;
         nar2_q    <= 1'b0;
         zero2_q   <= 1'b0;
         sow2_q    <= 1'b0;
         eow2_q    <= 1'b0;
         sticky2_q <= 1'b0;
         frac2_q   <= '0;
         scale2_q  <= '0;
         rts_q     <= 1'b0;
         sow_o_q   <= 1'b0;
         eow_o_q   <= 1'b0;
         posit_q   <= '0;
      end else begin
         rtr_q     <= rtr_d;
         v1_q      <= v1_d;
         neg1_q    <= neg1_d;
         nar1_q    <= nar1_d;
         zero1_q   <= zero1_d;
         sow1_q    <= sow1_d;
         eow1_q    <= eow1_d;
         mag1_q    <= mag1_d;
         v2_q      <= v2_d;
         neg2_q    <= neg2_d;
         nar2_q    <= nar2_d;
         zero2_q   <= zero2_d;
         sow2_q    <= sow2_d;
         eow2_q    <= eow2_d;
         sticky2_q <= sticky2_d;
         frac2_q   <= frac2_d;
         scale2_q  <= scale2_d;
         rts_q     <= rts_d;
         sow_o_q   <= sow_o_d;
         eow_o_q   <= eow_o_d;
         posit_q   <= posit_d;
      end
   end

   assign rtr_o   = rtr_q;
   assign rts_o   = rts_q;
   assign sow_o   = sow_o_q;
   assign eow_o   = eow_o_q;
   assign posit_o = posit_q;
   assign sign_o  = posit_q[3];
   assign zero_o  = (posit_q == POSIT4_ZERO);
   assign NaR_o   = (posit_q == POSIT4_NAR);

endmodule
